accel_input_feeder: RTL

// Core-side supplier of activations and weights for the conv2d engine. Reads

---
 rtl/accel_input_feeder_if.sv | 40 ++++
 rtl/accel_input_feeder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/accel_input_feeder_if.sv
// rtl/accel_input_feeder_if.sv - memory-side and engine-side signals of the conv2d input feeder
// master : feeder side, drives memory read strobes/addresses and engine beats
// slave  : memories/engine side, returns read data and the data-request line
// o_dmem_en/o_dmem_addr, i_dmem_rdata : activation memory read port (1-cycle latency)
// o_wmem_en/o_wmem_addr, i_wmem_rdata : weight memory read port (1-cycle latency)
// i_data_req, o_data/o_data_val       : activation beats to the engine
// o_weight/o_weight_val               : weight beats to the engine
interface accel_input_feeder_if #(
   parameter int BIT_WIDTH   = 8,
   parameter int NUM_CHANNEL = 3,
   parameter int NUM_KERNEL  = 4,
   parameter int ADDR_WIDTH  = 16
);
   localparam int DATA_W = BIT_WIDTH * NUM_CHANNEL;
   localparam int WGT_W  = DATA_W * NUM_KERNEL;

   logic                  o_dmem_en;
   logic [ADDR_WIDTH-1:0] o_dmem_addr;
   logic [DATA_W-1:0]     i_dmem_rdata;
   logic                  o_wmem_en;
   logic [ADDR_WIDTH-1:0] o_wmem_addr;
   logic [WGT_W-1:0]      i_wmem_rdata;
   logic                  i_data_req;
   logic [DATA_W-1:0]     o_data;
   logic                  o_data_val;
   logic [WGT_W-1:0]      o_weight;
   logic                  o_weight_val;

   modport master (
      output o_dmem_en, o_dmem_addr, o_wmem_en, o_wmem_addr,
             o_data, o_data_val, o_weight, o_weight_val,
      input  i_dmem_rdata, i_wmem_rdata, i_data_req
   );

   modport slave (
      input  o_dmem_en, o_dmem_addr, o_wmem_en, o_wmem_addr,
             o_data, o_data_val, o_weight, o_weight_val,
      output i_dmem_rdata, i_wmem_rdata, i_data_req
   );
endinterface

// File: rtl/accel_input_feeder.sv
// rtl/accel_input_feeder.sv - conv2d input feeder: weight preload, then request-driven activation stream
// clk, rst (sync, active high)        : clock and reset
// i_start / o_busy / o_done           : transfer control
// i_conf_{data,wgt}_{base,len}        : transfer config, captured on accepted start
// bus (accel_input_feeder_if.master)  : memory read ports and engine beat ports
module accel_input_feeder #(
   parameter int BIT_WIDTH   = 8,
   parameter int NUM_CHANNEL = 3,
   parameter int NUM_KERNEL  = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int REG_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   output logic                 o_busy,
   output logic                 o_done,
   input  logic [REG_WIDTH-1:0] i_conf_data_base,
   input  logic [REG_WIDTH-1:0] i_conf_data_len,
   input  logic [REG_WIDTH-1:0] i_conf_wgt_base,
   input  logic [REG_WIDTH-1:0] i_conf_wgt_len,
   accel_input_feeder_if.master bus
);
   localparam int DATA_W = BIT_WIDTH * NUM_CHANNEL;
   localparam int WGT_W  = DATA_W * NUM_KERNEL;

   typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DONE} state_e;

   state_e                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic [REG_WIDTH-1:0]  dlen_q;
   logic [REG_WIDTH-1:0]  wlen_q;
   logic [REG_WIDTH-1:0]  dcnt_q;
   logic [REG_WIDTH-1:0]  wcnt_q;
   logic [ADDR_WIDTH-1:0] daddr_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic                  dval_q;
   logic                  wval_q;
   logic [DATA_W-1:0]     data_hold_q;
   logic [WGT_W-1:0]      wgt_hold_q;
   logic                  dmem_rd;
   logic                  wmem_rd;
   logic                  unused_conf_bits;

   // Only the low address bits of the base registers are meaningful.
   assign unused_conf_bits = ^{i_conf_data_base[REG_WIDTH-1:ADDR_WIDTH],
                               i_conf_wgt_base[REG_WIDTH-1:ADDR_WIDTH]};

   // Counters only ever step up to their length, so != doubles as "more to issue".
   assign wmem_rd = (state_q == S_LOAD_W) && (wcnt_q != wlen_q);
   // Activation reads follow the engine request in the same cycle, so the
   // beat lands exactly one cycle after the request.
   assign dmem_rd = (state_q == S_STREAM) && bus.i_data_req && (dcnt_q != dlen_q);

   assign bus.o_wmem_en    = wmem_rd;
   assign bus.o_wmem_addr  = waddr_q;
   assign bus.o_dmem_en    = dmem_rd;
   assign bus.o_dmem_addr  = daddr_q;
   assign bus.o_weight_val = wval_q;
   assign bus.o_data_val   = dval_q;
   // Memory data is only valid in the cycle after the read; the hold
   // registers keep the last beat visible while val is low.
   assign bus.o_weight     = wval_q ? bus.i_wmem_rdata : wgt_hold_q;
   assign bus.o_data       = dval_q ? bus.i_dmem_rdata : data_hold_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dlen_q      <= '0;
         wlen_q      <= '0;
         dcnt_q      <= '0;
         wcnt_q      <= '0;
         daddr_q     <= '0;
         waddr_q     <= '0;
         dval_q      <= 1'b0;
         wval_q      <= 1'b0;
         data_hold_q <= '0;
         wgt_hold_q  <= '0;
      end else begin
         dval_q <= dmem_rd;
         wval_q <= wmem_rd;
         if (dval_q) data_hold_q <= bus.i_dmem_rdata;
         if (wval_q) wgt_hold_q  <= bus.i_wmem_rdata;
         if (wmem_rd) begin
            waddr_q <= waddr_q + ADDR_WIDTH'(1);
            wcnt_q  <= wcnt_q + REG_WIDTH'(1);
         end
         if (dmem_rd) begin
            daddr_q <= daddr_q + ADDR_WIDTH'(1);
            dcnt_q  <= dcnt_q + REG_WIDTH'(1);
         end
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  dlen_q  <= i_conf_data_len;
                  wlen_q  <= i_conf_wgt_len;
                  daddr_q <= i_conf_data_base[ADDR_WIDTH-1:0];
                  waddr_q <= i_conf_wgt_base[ADDR_WIDTH-1:0];
                  dcnt_q  <= '0;
                  wcnt_q  <= '0;
                  busy_q  <= 1'b1;
                  if (i_conf_wgt_len != '0) begin
                     state_q <= S_LOAD_W;
                  end else if (i_conf_data_len != '0) begin
                     state_q <= S_STREAM;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_LOAD_W: begin
               // All reads issued: the last weight beat is on the bus this cycle.
               if (wcnt_q == wlen_q) begin
                  if (dlen_q != '0) begin
                     state_q <= S_STREAM;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               // All reads issued: the last activation beat is on the bus this cycle.
               if (dcnt_q == dlen_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule
